ldpc_app_load_ctrl: RTL and testbench

LDPC_APP_LOAD_CTRL -- requirements
Module: ldpc_app_load_ctrl

---
 rtl/ldpc_app_load_ctrl_pkg.sv | 35 +++
 rtl/ldpc_phase_cnt.sv | 71 +++++++
 rtl/ldpc_app_load_ctrl.sv | 143 ++++++++++++++
 tb/tb_ldpc_app_load_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_app_load_ctrl_pkg.sv
// Shared encodings and constants for the LDPC APP load controller.
// Holds FSM state codes, code-rate codes and block/phase geometry.
package ldpc_app_load_ctrl_pkg;

    localparam int unsigned ST_W   = 3;
    localparam int unsigned BEAT_W = 8;
    localparam int unsigned RATE_W = 3;
    localparam int unsigned PH_W   = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_REQ   = 3'd1;
    localparam logic [ST_W-1:0] ST_PRIME = 3'd2;
    localparam logic [ST_W-1:0] ST_LOAD  = 3'd3;
    localparam logic [ST_W-1:0] ST_DRAIN = 3'd4;

    localparam logic [RATE_W-1:0] RATE_2_3 = 3'd1;
    localparam logic [RATE_W-1:0] RATE_7_8 = 3'd2;

    localparam int unsigned PHASE_LEN      = 16;
    localparam int unsigned PHASE3_LEN_2_3 = 128;
    localparam int unsigned BLK_LEN_2_3    = 176;
    localparam int unsigned BLK_LEN_7_8    = 48;

    // Beats in a given phase; only rate 2/3 phase 3 is long.
    function automatic logic [BEAT_W-1:0] phase_len(input logic [RATE_W-1:0] rate,
                                                    input logic [PH_W-1:0]   phase);
        if (rate == RATE_2_3 && phase == 2'd3) return BEAT_W'(PHASE3_LEN_2_3);
        return BEAT_W'(PHASE_LEN);
    endfunction

    function automatic logic [PH_W-1:0] last_phase(input logic [RATE_W-1:0] rate);
        return (rate == RATE_7_8) ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/ldpc_phase_cnt.sv
// Beat/phase counter for one LOAD block, plus the ROM address that leads
// each phase change so the read data is ready when sub_x switches.
module ldpc_phase_cnt
    import ldpc_app_load_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_LEAD = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    input  logic              adv_i,
    input  logic [RATE_W-1:0] rate_i,
    output logic [PH_W-1:0]   sub_x_o,
    output logic [PH_W-1:0]   buf_addr_o,
    output logic              last_o
);

    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [PH_W-1:0]   addr_q, addr_d;
    logic              last_q, last_d;
    logic [BEAT_W-1:0] lead_c;

    // Everything clears whenever the next cycle is not a LOAD beat.
    always_comb begin
        beat_d  = '0;
        phase_d = '0;
        addr_d  = '0;
        last_d  = 1'b0;
        lead_c  = '0;
        if (run_i) begin
            beat_d  = beat_q;
            phase_d = phase_q;
            addr_d  = addr_q;
            if (adv_i) begin
                if (beat_q == phase_len(rate_i, phase_q) - 8'd1) begin
                    beat_d  = '0;
                    phase_d = phase_q + 2'd1;
                end else begin
                    beat_d = beat_q + 8'd1;
                end
            end
            lead_c = phase_len(rate_i, phase_d) - 8'd1 - BEAT_W'(ADDR_LEAD);
            if (adv_i && beat_d == lead_c) begin
                // Rate 7/8 has no phase 3, so the last lead rewinds to ROM 0.
                addr_d = (rate_i == RATE_7_8 && phase_d == 2'd2) ? 2'd0 : addr_q + 2'd1;
            end
            last_d = (phase_d == last_phase(rate_i)) &&
                     (beat_d == phase_len(rate_i, phase_d) - 8'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q  <= '0;
            phase_q <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            beat_q  <= beat_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
        end
    end

    assign sub_x_o    = phase_q;
    assign buf_addr_o = addr_q;
    assign last_o     = last_q;

endmodule

// File: rtl/ldpc_app_load_ctrl.sv
// Sequences APP message loading into the LDPC decoder: handshakes each block,
// primes the ROM read pipeline, streams the block, then waits for decode.
module ldpc_app_load_ctrl
    import ldpc_app_load_ctrl_pkg::*;
#(
    parameter int unsigned BLK_NUM   = 8,
    parameter int unsigned ADDR_LEAD = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [RATE_W-1:0] iLs,
    input  logic              buffer_ready,
    input  logic              decode_valid,
    input  logic [2:0]        decode_valid_cnt,
    output logic              buffer_valid,
    output logic              buffer_start,
    output logic              buffer_last,
    output logic [PH_W-1:0]   sub_x,
    output logic [PH_W-1:0]   buf_addr,
    output logic [RATE_W-1:0] rate_sel,
    output logic [3:0]        blk_cnt,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int unsigned CNT_W = 4;

    logic [ST_W-1:0]   state_q, state_d;
    logic              prime_q, prime_d;
    logic [RATE_W-1:0] rate_sel_q, rate_sel_d;
    logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              first_q, first_d;
    logic              run_c, adv_c;
    logic              beat_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            prime_q    <= 1'b0;
            rate_sel_q <= '0;
            blk_cnt_q  <= '0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prime_q    <= prime_d;
            rate_sel_q <= rate_sel_d;
            blk_cnt_q  <= blk_cnt_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            first_q    <= first_d;
        end
    end

    // Next state and registered-output next values; abort wins over all.
    always_comb begin
        state_d    = state_q;
        prime_d    = 1'b0;
        rate_sel_d = rate_sel_q;
        blk_cnt_d  = blk_cnt_q;
        done_d     = done_q;
        cfg_err_d  = 1'b0;
        if (abort) begin
            state_d   = ST_IDLE;
            blk_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (iLs == RATE_2_3 || iLs == RATE_7_8) begin
                            rate_sel_d = iLs;
                            blk_cnt_d  = '0;
                            done_d     = 1'b0;
                            state_d    = ST_REQ;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (buffer_ready) state_d = ST_PRIME;
                end
                ST_PRIME: begin
                    if (prime_q) state_d = ST_LOAD;
                    else         prime_d = 1'b1;
                end
                ST_LOAD: begin
                    if (beat_last) begin
                        blk_cnt_d = blk_cnt_q + 4'd1;
                        state_d   = (blk_cnt_q + 4'd1 == CNT_W'(BLK_NUM)) ? ST_DRAIN : ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (decode_valid && decode_valid_cnt == 3'(BLK_NUM - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        run_c   = (state_d == ST_LOAD);
        adv_c   = (state_q == ST_LOAD);
        valid_d = run_c;
        first_d = run_c && !adv_c;
        busy_d  = (state_d != ST_IDLE);
    end

    ldpc_phase_cnt #(
        .ADDR_LEAD (ADDR_LEAD)
    ) u_phase_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (run_c),
        .adv_i      (adv_c),
        .rate_i     (rate_sel_q),
        .sub_x_o    (sub_x),
        .buf_addr_o (buf_addr),
        .last_o     (beat_last)
    );

    assign buffer_valid = valid_q;
    assign buffer_start = first_q;
    assign buffer_last  = beat_last;
    assign rate_sel     = rate_sel_q;
    assign blk_cnt      = blk_cnt_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_ldpc_app_load_ctrl.sv
// Self-checking bench for ldpc_app_load_ctrl: expected LOAD beats are queued
// when a block is launched and compared beat by beat as the DUT streams them.
module tb_ldpc_app_load_ctrl;
    import ldpc_app_load_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, buffer_ready, decode_valid;
    logic [2:0] iLs, decode_valid_cnt;
    logic       buffer_valid, buffer_start, buffer_last, busy, done, cfg_err;
    logic [1:0] sub_x, buf_addr;
    logic [2:0] rate_sel;
    logic [3:0] blk_cnt;
    logic [16:0] all_out;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       st;
        logic       lst;
        logic [1:0] sx;
        logic [1:0] ad;
    } beat_t;
    beat_t sb[$];

    always #5 clk = ~clk;

    assign all_out = {buffer_valid, buffer_start, buffer_last, sub_x, buf_addr,
                      rate_sel, blk_cnt, busy, done, cfg_err};

    ldpc_app_load_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .iLs              (iLs),
        .buffer_ready     (buffer_ready),
        .decode_valid     (decode_valid),
        .decode_valid_cnt (decode_valid_cnt),
        .buffer_valid     (buffer_valid),
        .buffer_start     (buffer_start),
        .buffer_last      (buffer_last),
        .sub_x            (sub_x),
        .buf_addr         (buf_addr),
        .rate_sel         (rate_sel),
        .blk_cnt          (blk_cnt),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err)
    );

    // Reference beat: phases of 16 (rate 2/3 phase 3 is 128), address leads by 4 beats.
    function automatic beat_t exp_beat(input int r, input int b);
        beat_t e;
        int    len;
        len   = (r == 1) ? int'(BLK_LEN_2_3) : int'(BLK_LEN_7_8);
        e.st  = (b == 0);
        e.lst = (b == len - 1);
        e.sx  = (b < 48) ? 2'(b / 16) : 2'd3;
        if      (b < 12)  e.ad = 2'd0;
        else if (b < 28)  e.ad = 2'd1;
        else if (b < 44)  e.ad = 2'd2;
        else if (r == 2)  e.ad = 2'd0;
        else if (b < 172) e.ad = 2'd3;
        else              e.ad = 2'd0;
        return e;
    endfunction

    task automatic push_block(input int r);
        int len;
        len = (r == 1) ? int'(BLK_LEN_2_3) : int'(BLK_LEN_7_8);
        for (int b = 0; b < len; b++) sb.push_back(exp_beat(r, b));
    endtask

    task automatic do_start(input int r);
        start = 1'b1;
        iLs   = 3'(r);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    // Waits for the block to start, then pops and compares one beat per cycle.
    task automatic consume(input int stop_at, input string tag, output int lat);
        beat_t e;
        int    b;
        lat = 0;
        while (buffer_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (buffer_valid !== 1'b1) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s_timeout: buffer_valid=%b want 1", tag, buffer_valid);
            sb.delete();
            return;
        end
        b = 0;
        forever begin
            e = sb.pop_front();
            n_assert++;
            if ({buffer_valid, buffer_start, buffer_last, sub_x, buf_addr} !== {1'b1, e}) begin
                n_fail++;
                if (n_fail < 30)
                    $display("FAIL %s beat %0d: got v=%b s=%b l=%b sx=%0d ad=%0d want v=1 s=%b l=%b sx=%0d ad=%0d",
                             tag, b, buffer_valid, buffer_start, buffer_last, sub_x, buf_addr,
                             e.st, e.lst, e.sx, e.ad);
            end
            if (b == stop_at || sb.size() == 0) break;
            @(negedge clk);
            b++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; iLs = 3'd0;
        buffer_ready = 1'b0; decode_valid = 1'b0; decode_valid_cnt = 3'd0;
        repeat (2) @(negedge clk);
        n_assert++;
        if (all_out !== 17'd0) begin
            n_fail++; $display("FAIL reset_hold: outputs=%h want 0", all_out);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_assert++;
        if (all_out !== 17'd0) begin
            n_fail++; $display("FAIL reset_release: outputs=%h want 0", all_out);
        end
    endtask

    task automatic test_rate23();
        int lat;
        buffer_ready = 1'b1;
        do_start(1);
        n_assert++;
        if ({busy, rate_sel} !== {1'b1, 3'd1}) begin
            n_fail++; $display("FAIL r23_accept: busy=%b rate_sel=%0d want 1,1", busy, rate_sel);
        end
        push_block(1);
        consume(-1, "r23", lat);
        n_assert++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL r23_prime_latency: got %0d cycles want 3", lat);
        end
        @(negedge clk);
        n_assert++;
        if ({buffer_valid, blk_cnt, busy} !== {1'b0, 4'd1, 1'b1}) begin
            n_fail++; $display("FAIL r23_after: v=%b blk_cnt=%0d busy=%b want 0,1,1", buffer_valid, blk_cnt, busy);
        end
        do_abort();
    endtask

    task automatic test_rate78();
        int lat;
        buffer_ready = 1'b1;
        do_start(2);
        n_assert++;
        if (rate_sel !== 3'd2) begin
            n_fail++; $display("FAIL r78_rate_sel: got %0d want 2", rate_sel);
        end
        push_block(2);
        consume(-1, "r78", lat);
        @(negedge clk);
        n_assert++;
        if ({buffer_valid, sub_x, buf_addr, blk_cnt} !== {1'b0, 2'd0, 2'd0, 4'd1}) begin
            n_fail++; $display("FAIL r78_after: v=%b sx=%0d ad=%0d blk_cnt=%0d want 0,0,0,1",
                               buffer_valid, sub_x, buf_addr, blk_cnt);
        end
        do_abort();
    endtask

    task automatic test_bad_rate();
        int codes[4] = '{0, 3, 4, 7};
        int bad;
        buffer_ready = 1'b1;
        foreach (codes[k]) begin
            do_start(codes[k]);
            n_assert++;
            if ({cfg_err, busy} !== 2'b10) begin
                n_fail++; $display("FAIL bad_rate_%0d_pulse: cfg_err=%b busy=%b want 1,0", codes[k], cfg_err, busy);
            end
            @(negedge clk);
            n_assert++;
            if ({cfg_err, busy} !== 2'b00) begin
                n_fail++; $display("FAIL bad_rate_%0d_clear: cfg_err=%b busy=%b want 0,0", codes[k], cfg_err, busy);
            end
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (buffer_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_assert++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bad_rate_idle: %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_abort();
        int lat;
        buffer_ready = 1'b1;
        do_start(1);
        push_block(1);
        consume(100, "abort_pre", lat);
        do_abort();
        n_assert++;
        if ({buffer_valid, buffer_start, buffer_last, sub_x, buf_addr, blk_cnt, busy} !== 12'd0) begin
            n_fail++; $display("FAIL abort_idle: v=%b s=%b l=%b sx=%0d ad=%0d blk_cnt=%0d busy=%b want all 0",
                               buffer_valid, buffer_start, buffer_last, sub_x, buf_addr, blk_cnt, busy);
        end
        sb.delete();
        do_start(1);
        push_block(1);
        consume(-1, "abort_restart", lat);
        do_abort();
    endtask

    task automatic test_full_run();
        int lat;
        int bad;
        buffer_ready = 1'b1;
        do_start(2);
        for (int i = 0; i < 8; i++) begin
            push_block(2);
            consume(-1, $sformatf("run_blk%0d", i), lat);
            n_assert++;
            if (lat !== 3) begin
                n_fail++; $display("FAIL run_blk%0d_latency: got %0d want 3", i, lat);
            end
            if (i < 7) begin
                buffer_ready = 1'b0;
                bad = 0;
                repeat (20) begin
                    @(negedge clk);
                    if ({buffer_valid, busy, blk_cnt} !== {1'b0, 1'b1, 4'(i + 1)}) bad++;
                end
                n_assert++;
                if (bad != 0) begin
                    n_fail++; $display("FAIL run_req_wait%0d: %0d bad cycles, blk_cnt=%0d want %0d", i, bad, blk_cnt, i + 1);
                end
                buffer_ready = 1'b1;
            end
        end
        @(negedge clk);
        n_assert++;
        if ({blk_cnt, busy, done, buffer_valid} !== {4'd8, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL run_drain: blk_cnt=%0d busy=%b done=%b v=%b want 8,1,0,0", blk_cnt, busy, done, buffer_valid);
        end
        decode_valid = 1'b1; decode_valid_cnt = 3'd6;
        @(negedge clk);
        n_assert++;
        if ({busy, done} !== 2'b10) begin
            n_fail++; $display("FAIL run_wrong_cnt: busy=%b done=%b want 1,0", busy, done);
        end
        decode_valid_cnt = 3'd7;
        @(negedge clk);
        decode_valid = 1'b0; decode_valid_cnt = 3'd0;
        n_assert++;
        if ({busy, done} !== 2'b01) begin
            n_fail++; $display("FAIL run_done: busy=%b done=%b want 0,1", busy, done);
        end
        repeat (3) @(negedge clk);
        do_abort();
        n_assert++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL run_done_hold: done=%b want 1", done);
        end
        do_start(2);
        n_assert++;
        if ({busy, done} !== 2'b10) begin
            n_fail++; $display("FAIL run_done_clear: busy=%b done=%b want 1,0", busy, done);
        end
        do_abort();
    endtask

    task automatic test_disturb();
        int lat;
        buffer_ready = 1'b1;
        do_start(2);
        push_block(2);
        fork
            consume(-1, "disturb", lat);
            begin
                repeat (10) @(negedge clk);
                iLs = 3'd1; start = 1'b1; buffer_ready = 1'b0;
                @(negedge clk);
                start = 1'b0; iLs = 3'd6;
            end
        join
        repeat (5) @(negedge clk);
        n_assert++;
        if ({buffer_valid, rate_sel, blk_cnt, busy} !== {1'b0, 3'd2, 4'd1, 1'b1}) begin
            n_fail++; $display("FAIL disturb_after: v=%b rate_sel=%0d blk_cnt=%0d busy=%b want 0,2,1,1",
                               buffer_valid, rate_sel, blk_cnt, busy);
        end
        do_abort();
        buffer_ready = 1'b1;
        do_start(1);
        push_block(1);
        consume(50, "pre_reset", lat);
        rst_n = 1'b0;
        #1;
        n_assert++;
        if (all_out !== 17'd0) begin
            n_fail++; $display("FAIL reset_async: outputs=%h want 0", all_out);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_assert++;
        if (all_out !== 17'd0) begin
            n_fail++; $display("FAIL reset_after_load: outputs=%h want 0", all_out);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rate23();
        test_rate78();
        test_bad_rate();
        test_abort();
        test_full_run();
        test_disturb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
